// File: rtl/alu_div_seq.sv
// Sequential RV32M divide/remainder engine that borrows the shared ALU:
// restoring division, one quotient bit per SLTU-compare / SUB cycle pair.
module alu_div_seq #(
    parameter int          WIDTH   = 32,
    parameter logic [3:0]  OP_SUB  = 4'b1000,
    parameter logic [3:0]  OP_SLTU = 4'b0011
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] alu_s1_o,
    output logic [WIDTH-1:0] alu_s2_o,
    output logic [3:0]       alu_op_o,
    input  logic [WIDTH-1:0] alu_d_i
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CMP, S_SUB, S_FIXUP, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ge_q, ge_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   rem_sh;
    logic               signed_op;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk_i) begin
        op_q   <= op_d;
        dvd_q  <= dvd_d;
        dvs_q  <= dvs_d;
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        cnt_q  <= cnt_d;
        ge_q   <= ge_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        op_d      = op_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        ge_d      = ge_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        alu_s1_o  = '0;
        alu_s2_o  = '0;
        alu_op_o  = 4'b0000;
        signed_op = ~op_q[0];
        rem_sh    = {rem_q[WIDTH-2:0], dvd_q[cnt_q]};

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d  = op_i;
                    dvd_d = dividend_i;
                    dvs_d = divisor_i;
                    // Divide-by-zero and signed overflow skip the iteration entirely.
                    if (divisor_i == '0) begin
                        result_d = op_i[1] ? dividend_i : '1;
                        state_d  = S_DONE;
                    end else if (!op_i[0] && dividend_i == MIN_NEG && divisor_i == '1) begin
                        result_d = op_i[1] ? '0 : MIN_NEG;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                dvd_d   = (signed_op && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
                dvs_d   = (signed_op && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
                qneg_d  = signed_op && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                rneg_d  = signed_op && dvd_q[WIDTH-1];
                rem_d   = '0;
                cnt_d   = CNT_W'(WIDTH - 1);
                state_d = S_CMP;
            end
            S_CMP: begin
                alu_s1_o = rem_sh;
                alu_s2_o = dvs_q;
                alu_op_o = OP_SLTU;
                // A bit shifted out of rem means rem_sh exceeds any 32-bit divisor.
                ge_d     = rem_q[WIDTH-1] | ~alu_d_i[0];
                rem_d    = rem_sh;
                state_d  = S_SUB;
            end
            S_SUB: begin
                alu_s1_o     = rem_q;
                alu_s2_o     = dvs_q;
                alu_op_o     = OP_SUB;
                if (ge_q) rem_d = alu_d_i;
                quo_d[cnt_q] = ge_q;
                if (cnt_q == '0) begin
                    state_d = S_FIXUP;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = S_CMP;
                end
            end
            S_FIXUP: begin
                result_d = op_q[1] ? (rneg_q ? -rem_q : rem_q)
                                   : (qneg_q ? -quo_q : quo_q);
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for alu_div_seq: vector table plus reset and start-while-busy sequences.
module tb_alu_div_seq;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b0011;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i, divisor_i;
    logic        busy_o, done_o;
    logic [31:0] result_o, alu_s1_o, alu_s2_o, alu_d;
    logic [3:0]  alu_op_o;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_div_seq #(.WIDTH(32), .OP_SUB(OP_SUB), .OP_SLTU(OP_SLTU)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .busy_o(busy_o),
        .done_o(done_o), .result_o(result_o), .alu_s1_o(alu_s1_o),
        .alu_s2_o(alu_s2_o), .alu_op_o(alu_op_o), .alu_d_i(alu_d)
    );

    always #5 clk_i = ~clk_i;

    // Reference ALU
    always_comb begin
        case (alu_op_o)
            4'b0000: alu_d = alu_s1_o + alu_s2_o;
            OP_SUB:  alu_d = alu_s1_o - alu_s2_o;
            OP_SLTU: alu_d = {31'b0, alu_s1_o < alu_s2_o};
            default: alu_d = 32'h0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one operation; lat = samples after the accepting edge until done (1-based).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, output logic [31:0] res, output int lat,
                          output int nops, output bit seq_ok);
        op_i = op; dividend_i = a; divisor_i = b; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        lat = 1; nops = 0; seq_ok = 1'b1;
        while (!done_o && lat < 200) begin
            if (alu_op_o != 4'b0000) begin
                if (alu_op_o != ((nops % 2 == 0) ? OP_SLTU : OP_SUB)) seq_ok = 1'b0;
                nops++;
            end
            if (lat == inj_at) begin
                start_i = 1'b1; op_i = 2'b10; dividend_i = 32'd8; divisor_i = 32'd3;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk_i); #1;
            lat++;
        end
        start_i = 1'b0;
        res = result_o;
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a, b, exp;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [31:0] res;
        int lat, nops;
        bit seq_ok;

        vecs[0]  = '{"divu_100_7",    2'b01, 32'd100,      32'd7,        32'd14,       67};
        vecs[1]  = '{"remu_100_7",    2'b11, 32'd100,      32'd7,        32'd2,        67};
        vecs[2]  = '{"div_m7_2",      2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 67};
        vecs[3]  = '{"rem_m7_2",      2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 67};
        vecs[4]  = '{"rem_7_m2",      2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        67};
        vecs[5]  = '{"divu_big",      2'b01, 32'hFFFFFFFF, 32'h80000001, 32'd1,        67};
        vecs[6]  = '{"remu_big",      2'b11, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 67};
        vecs[7]  = '{"div_by0",       2'b00, 32'd1234,     32'd0,        32'hFFFFFFFF, 1};
        vecs[8]  = '{"remu_5_0",      2'b11, 32'd5,        32'd0,        32'd5,        1};
        vecs[9]  = '{"div_ovf",       2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[10] = '{"rem_ovf",       2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vecs[11] = '{"divu_3_10",     2'b01, 32'd3,        32'd10,       32'd0,        67};
        vecs[12] = '{"remu_3_10",     2'b11, 32'd3,        32'd10,       32'd3,        67};
        vecs[13] = '{"div_min_2",     2'b00, 32'h80000000, 32'd2,        32'hC0000000, 67};
        vecs[14] = '{"divu_min_m1",   2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        67};

        reset_i = 1'b1; start_i = 1'b0; op_i = 2'b00; dividend_i = '0; divisor_i = '0;
        #12;
        check("rst_busy",   {31'b0, busy_o}, 32'd0);
        check("rst_done",   {31'b0, done_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_aluop",  {28'b0, alu_op_o}, 32'd0);
        @(negedge clk_i); reset_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat, nops, seq_ok);
            check({vecs[i].name, "_res"}, res, vecs[i].exp);
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            @(posedge clk_i); #1;
            check({vecs[i].name, "_done_pulse"}, {31'b0, done_o}, 32'd0);
            check({vecs[i].name, "_busy_drop"},  {31'b0, busy_o}, 32'd0);
        end

        // Start pulse mid-division must not disturb the operation in flight.
        run_op(2'b01, 32'd100, 32'd7, 5, res, lat, nops, seq_ok);
        check("ign_res",   res, 32'd14);
        check("ign_lat",   lat, 32'd67);
        check("ign_nops",  nops, 32'd64);
        check("ign_seq",   {31'b0, seq_ok}, 32'd1);
        @(posedge clk_i); #1;
        check("ign_idle",  {31'b0, busy_o}, 32'd0);

        // Asynchronous reset during iteration.
        op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (19) @(posedge clk_i);
        #3;
        check("mid_busy_before", {31'b0, busy_o}, 32'd1);
        reset_i = 1'b1;
        #1;
        check("mid_rst_busy",   {31'b0, busy_o}, 32'd0);
        check("mid_rst_done",   {31'b0, done_o}, 32'd0);
        check("mid_rst_result", result_o, 32'd0);
        check("mid_rst_s1",     alu_s1_o, 32'd0);
        check("mid_rst_s2",     alu_s2_o, 32'd0);
        check("mid_rst_aluop",  {28'b0, alu_op_o}, 32'd0);
        @(negedge clk_i); reset_i = 1'b0;
        @(posedge clk_i); #1;
        run_op(2'b01, 32'd9, 32'd3, 0, res, lat, nops, seq_ok);
        check("post_rst_res", res, 32'd3);
        check("post_rst_lat", lat, 32'd67);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
